// File: rtl/regfile_param.sv
// regfile_param: parametrised integer register file with byte-enabled writes,
// same-cycle write-to-read bypass, a per-register busy scoreboard and a
// sequential clear engine that zeroes the array after reset or on clr.
module regfile_param #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              ready,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [XLEN-1:0]   wd,
  input  logic [XLEN/8-1:0] wbe,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              set_busy,
  input  logic [AW-1:0]     set_addr
);

  localparam int NREGS = 1 << AW;
  localparam int NB    = XLEN / 8;
  localparam int NRP   = 2;
  localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                 state;
  logic [AW:0]            ptr;
  logic [XLEN-1:0]        mem [NREGS];
  logic [NREGS-1:0]       busy;

  logic                   wr_ok;
  logic                   set_ok;
  logic [NRP-1:0][AW-1:0] ra_v;
  logic [NRP-1:0][XLEN-1:0] rd_v;
  logic [NRP-1:0]         bz_v;

  // Register 0 is hard-wired when ZERO_REG, so writes and busy-sets to it drop.
  assign wr_ok  = ready && we && !((ZERO_REG != 0) && (wa == '0));
  assign set_ok = ready && set_busy && !((ZERO_REG != 0) && (set_addr == '0));

  // Sweep sequencer: CLEAR walks ptr over every entry, then RUN until clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr) begin
            ptr <= '0;
          end else if (ptr == LAST) begin
            ptr   <= '0;
            state <= RUN;
            ready <= 1'b1;
          end else begin
            ptr <= ptr + (AW+1)'(1);
          end
        end
        RUN: begin
          if (clr) begin
            ptr   <= '0;
            state <= CLEAR;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage: no reset network; the sweep zeroes entries one per cycle, and
  // byte-masked writes land only in RUN (ready gates wr_ok).
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr[AW-1:0]] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < NB; k++)
        if (wbe[k]) mem[wa][8*k +: 8] <= wd[8*k +: 8];
    end
  end

  // Scoreboard: write clears, set_busy sets afterwards so set wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (clr) begin
      busy <= '0;
    end else begin
      if (wr_ok)  busy[wa]       <= 1'b0;
      if (set_ok) busy[set_addr] <= 1'b1;
    end
  end

  assign ra_v = {ra2, ra1};

  // Read ports: stored word, optionally patched with same-cycle write bytes,
  // forced to zero while not ready or for the hard-wired zero register.
  always_comb begin
    rd_v = '0;
    bz_v = '0;
    for (int p = 0; p < NRP; p++) begin
      rd_v[p] = mem[ra_v[p]];
      if ((BYPASS != 0) && wr_ok && (wa == ra_v[p]))
        for (int k = 0; k < NB; k++)
          if (wbe[k]) rd_v[p][8*k +: 8] = wd[8*k +: 8];
      bz_v[p] = busy[ra_v[p]];
      if (!ready || ((ZERO_REG != 0) && (ra_v[p] == '0))) begin
        rd_v[p] = '0;
        bz_v[p] = 1'b0;
      end
    end
  end

  assign rd1   = rd_v[0];
  assign rd2   = rd_v[1];
  assign busy1 = bz_v[0];
  assign busy2 = bz_v[1];

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed plus randomized checks of regfile_param against a
// word-level reference model (array of words, busy flags, sweep countdown).
module tb_regfile_param;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int N    = 32;
  localparam int NB   = 4;
  localparam int AW8  = 3;
  localparam int N8   = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic clr = 1'b0, we = 1'b0, set_busy = 1'b0;
  logic [AW-1:0] wa = '0, ra1 = '0, ra2 = '0, set_addr = '0;
  logic [XLEN-1:0] wd = '0;
  logic [NB-1:0] wbe = '0;
  logic ready, busy1, busy2;
  logic [XLEN-1:0] rd1, rd2;

  logic clr8 = 1'b0, we8 = 1'b0, set_busy8 = 1'b0;
  logic [AW8-1:0] wa8 = '0, ra8a = '0, ra8b = '0, set_addr8 = '0;
  logic [XLEN-1:0] wd8 = '0;
  logic [NB-1:0] wbe8 = '0;
  logic ready8, busy8a, busy8b;
  logic [XLEN-1:0] rd8a, rd8b;

  regfile_param #(.XLEN(XLEN), .AW(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready),
    .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .set_busy(set_busy), .set_addr(set_addr)
  );

  regfile_param #(.XLEN(XLEN), .AW(AW8), .ZERO_REG(1), .BYPASS(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr8), .ready(ready8),
    .we(we8), .wa(wa8), .wd(wd8), .wbe(wbe8),
    .ra1(ra8a), .ra2(ra8b), .rd1(rd8a), .rd2(rd8b),
    .busy1(busy8a), .busy2(busy8b), .set_busy(set_busy8), .set_addr(set_addr8)
  );

  always #5 clk = ~clk;

  // reference model
  logic [XLEN-1:0] m_mem [N];
  bit m_busy [N];
  bit m_ready, m8_ready;
  int m_left, m8_left;
  int checks = 0, errors = 0;

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old,
                                            input logic [XLEN-1:0] nw,
                                            input logic [NB-1:0] be);
    for (int k = 0; k < NB; k++) if (be[k]) old[8*k +: 8] = nw[8*k +: 8];
    return old;
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] ra);
    logic [XLEN-1:0] r;
    if (!m_ready || ra == 0) return '0;
    r = m_mem[ra];
    if (we && wa == ra) r = merge(r, wd, wbe);
    return r;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] ra);
    return m_ready && (ra != 0) && m_busy[ra];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 0; m_left = N; m8_ready = 0; m8_left = N8;
    for (int i = 0; i < N; i++) m_busy[i] = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    if (m_ready) begin
      if (clr) begin
        m_ready = 0; m_left = N;
        for (int i = 0; i < N; i++) m_busy[i] = 0;
      end else begin
        if (we && wa != 0) begin
          m_mem[wa] = merge(m_mem[wa], wd, wbe);
          m_busy[wa] = 0;
        end
        if (set_busy && set_addr != 0) m_busy[set_addr] = 1;
      end
    end else begin
      if (clr) m_left = N; else m_left--;
      if (m_left == 0) begin
        m_ready = 1;
        for (int i = 0; i < N; i++) m_mem[i] = '0;
      end
    end
    if (m8_ready) begin
      if (clr8) begin m8_ready = 0; m8_left = N8; end
    end else begin
      if (clr8) m8_left = N8; else m8_left--;
      if (m8_left == 0) m8_ready = 1;
    end
  endtask

  task automatic look();
    #2;
    chk("ready", 32'(ready), 32'(m_ready));
    chk("rd1", rd1, exp_rd(ra1));
    chk("rd2", rd2, exp_rd(ra2));
    chk("busy1", 32'(busy1), 32'(exp_busy(ra1)));
    chk("busy2", 32'(busy2), 32'(exp_busy(ra2)));
    chk("ready8", 32'(ready8), 32'(m8_ready));
    chk("rd8", rd8a, '0);
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick();
    look();
    adv();
  endtask

  task automatic idle();
    we = 0; set_busy = 0; clr = 0; clr8 = 0; wbe = '0;
  endtask

  task automatic rand_in(input bit allow_clr);
    we = 1'($urandom); wa = AW'($urandom); wd = $urandom; wbe = NB'($urandom);
    ra1 = ($urandom_range(3) == 0) ? wa : AW'($urandom);
    ra2 = AW'($urandom);
    set_busy = 1'($urandom); set_addr = AW'($urandom);
    clr = allow_clr && ($urandom_range(63) == 0);
    ra8a = AW8'($urandom);
  endtask

  initial begin
    int cnt;
    logic [XLEN-1:0] v;
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    model_reset();
    #1;
    look();                                   // reset state
    @(posedge clk); #1;
    rst_n = 1;

    // sweep after reset: random writes must not land, ready after 32 edges
    cnt = 0;
    while (!ready && cnt < 100) begin rand_in(0); tick(); cnt++; end
    chk("sweep_len", cnt, 32);
    idle();
    for (int i = 0; i < N; i++) begin ra1 = AW'(i); ra2 = AW'(N-1-i); tick(); end

    // bypass then hold
    we = 1; wa = 5; wd = 32'hDEADBEEF; wbe = 4'hF; ra1 = 5; ra2 = 0;
    look(); chk("bypass", rd1, 32'hDEADBEEF); adv();
    idle(); look(); chk("hold", rd1, 32'hDEADBEEF); adv();

    // byte write, then busy set on 5 and wbe=0 write clears it
    we = 1; wd = 32'h000000AA; wbe = 4'h1; look(); adv();
    idle(); look(); chk("byte0", rd1, 32'hDEADBEAA); adv();
    set_busy = 1; set_addr = 5; look(); adv();
    idle(); look(); chk("busy5", 32'(busy1), 1); adv();
    we = 1; wd = 32'hFFFFFFFF; wbe = 4'h0;
    look(); chk("wbe0_byp", rd1, 32'hDEADBEAA); adv();
    idle(); look(); chk("wbe0_data", rd1, 32'hDEADBEAA);
    chk("wbe0_busy", 32'(busy1), 0); adv();

    // register 0 hard-wired
    we = 1; wa = 0; wd = 32'h12345678; wbe = 4'hF; set_busy = 1; set_addr = 0; ra1 = 0;
    look(); chk("r0_byp", rd1, 0); adv();
    idle(); look(); chk("r0_rd", rd1, 0); chk("r0_busy", 32'(busy1), 0); adv();

    // scoreboard on 7
    ra1 = 7; ra2 = 7; set_busy = 1; set_addr = 7;
    look(); chk("busy7_same", 32'(busy1), 0); adv();
    idle(); look(); chk("busy7_set", 32'(busy1), 1); adv();
    we = 1; wa = 7; wd = $urandom; wbe = 4'hF; set_busy = 1; set_addr = 7; look(); adv();
    idle(); look(); chk("busy7_win", 32'(busy2), 1); adv();
    we = 1; wa = 7; wbe = 4'hF; look(); chk("busy7_nobyp", 32'(busy1), 1); adv();
    idle(); look(); chk("busy7_clr", 32'(busy1), 0); adv();

    // random traffic with occasional clr
    for (int i = 0; i < 400; i++) begin rand_in(1); tick(); end

    // async reset in the middle of traffic
    rand_in(0); we = 1;
    rst_n = 0; model_reset();
    look(); chk("rst_ready", 32'(ready), 0);
    @(posedge clk); #1;
    rst_n = 1;
    idle();
    cnt = 0;
    while (!ready && cnt < 100) begin rand_in(0); tick(); cnt++; end
    chk("rst_sweep", cnt, 32);

    for (int i = 0; i < 200; i++) begin rand_in(1); tick(); end
    idle();
    cnt = 0;
    while (!ready && cnt < 100) begin tick(); cnt++; end

    // fill, clr, clr again at ptr=10
    for (int i = 1; i < N; i++) begin
      we = 1; wa = AW'(i); wd = $urandom | 32'h1; wbe = 4'hF;
      set_busy = 1; set_addr = AW'(N-i); tick();
    end
    idle(); clr = 1; tick(); clr = 0;
    for (int i = 0; i < 10; i++) begin rand_in(0); tick(); end
    idle(); clr = 1; tick(); clr = 0;
    cnt = 0;
    while (!ready && cnt < 100) begin rand_in(0); tick(); cnt++; end
    chk("clr_sweep", cnt, 32);
    idle();
    for (int i = 0; i < N; i++) begin
      ra1 = AW'(i); ra2 = AW'(N-1-i);
      look(); chk("clr_rd", rd1, 0); chk("clr_busy", 32'(busy2), 0); adv();
    end

    // AW=3 instance: 8-cycle sweep after clr
    clr8 = 1; tick(); clr8 = 0;
    cnt = 0;
    while (!ready8 && cnt < 100) begin ra8a = AW8'($urandom); tick(); cnt++; end
    chk("sweep8_len", cnt, 8);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
